// File: rtl/uart_rx_capture.sv
// 8N1 UART receiver: rx synchronizer, bit-centre sampling FSM, first-word fall-through
// byte FIFO with sticky overflow and a one-cycle framing-error pulse.
module uart_rx_capture #(
  parameter int unsigned DIV_WIDTH   = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx_i,
  input  logic [DIV_WIDTH-1:0]        baud_div_i,
  output logic [7:0]                  rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        busy_o,
  output logic                        frame_err_o,
  output logic                        overflow_o,
  input  logic                        clr_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count_o
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] FullCnt = (PtrW + 1)'(FIFO_DEPTH);
  localparam logic [PtrW:0] CntOne = (PtrW + 1)'(1);
  localparam logic [PtrW-1:0] PtrOne = PtrW'(1);
  localparam logic [DIV_WIDTH-1:0] MinDiv = DIV_WIDTH'(4);
  localparam logic [DIV_WIDTH-1:0] DivOne = DIV_WIDTH'(1);

  typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;

  // Input synchronizer; idles high so reset never looks like a start bit.
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rxs;

  always_ff @(posedge clk) begin
    if (rst) sync_q <= '1;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
  end

  assign rxs = sync_q[SYNC_STAGES-1];

  state_e               state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [2:0]           bit_q, bit_d;
  logic [7:0]           shreg_q, shreg_d;
  logic                 frame_err_q, frame_err_d;
  logic                 push;
  logic                 half_end, bit_end;

  assign half_end = (cnt_q == ((div_q >> 1) - DivOne));
  assign bit_end  = (cnt_q == (div_q - DivOne));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    div_d       = div_q;
    bit_d       = bit_q;
    shreg_d     = shreg_q;
    frame_err_d = 1'b0;
    push        = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs) begin
          cnt_d   = '0;
          div_d   = (baud_div_i < MinDiv) ? MinDiv : baud_div_i;
          state_d = StStart;
        end
      end
      StStart: begin
        if (half_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A start bit that is gone by its centre is treated as a glitch.
          state_d = rxs ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + DivOne;
        end
      end
      StData: begin
        if (bit_end) begin
          shreg_d = {rxs, shreg_q[7:1]};
          cnt_d   = '0;
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = StStop;
        end else begin
          cnt_d = cnt_q + DivOne;
        end
      end
      StStop: begin
        if (bit_end) begin
          if (rxs) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_d = 1'b1;
            state_d     = StBreak;
          end
        end else begin
          cnt_d = cnt_q + DivOne;
        end
      end
      StBreak: begin
        if (rxs) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      div_q       <= MinDiv;
      bit_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      bit_q       <= bit_d;
      shreg_q     <= shreg_d;
      frame_err_q <= frame_err_d;
    end
  end

  // FIFO; a pop in the same cycle frees the slot for a push into a full buffer.
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_q, rd_q;
  logic [PtrW:0]   count_q;
  logic            overflow_q;
  logic            full, pop, push_ok, ovf_set;

  assign rx_valid_o = (count_q != '0);
  assign full       = (count_q == FullCnt);
  assign pop        = rx_valid_o && rx_ready_i;
  assign push_ok    = push && (!full || pop);
  assign ovf_set    = push && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q      <= '{default: '0};
      wr_q       <= '0;
      rd_q       <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= shreg_q;
        wr_q        <= wr_q + PtrOne;
      end
      if (pop) rd_q <= rd_q + PtrOne;
      if (push_ok && !pop)      count_q <= count_q + CntOne;
      else if (!push_ok && pop) count_q <= count_q - CntOne;
      if (ovf_set)    overflow_q <= 1'b1;
      else if (clr_i) overflow_q <= 1'b0;
    end
  end

  assign rx_data_o    = mem_q[rd_q];
  assign busy_o       = (state_q != StIdle);
  assign frame_err_o  = frame_err_q;
  assign overflow_o   = overflow_q;
  assign fifo_count_o = count_q;

endmodule
